// File: rtl/adder_sched_pkg.sv
// Shared constants and the result-FIFO entry type for the adder pipeline scheduler.
package adder_sched_pkg;

  localparam int NREQ       = 4;
  localparam int WIDTH      = 32;
  localparam int ADD_LAT    = 5;
  localparam int FIFO_DEPTH = 8;
  localparam int ID_W       = $clog2(NREQ);

  // One completed operation as it sits in the result FIFO.
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] sum;
    logic             cout;
  } rsp_entry_t;

endpackage

// File: rtl/adder_pipe_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer, pointer advances past the winner only when the grant is taken.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    sync_reset,
  input  logic [NREQ-1:0]         req,
  input  logic                    enable,
  input  logic                    accept,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] idx;
  logic          found;

  // Scan requests starting at the pointer; NREQ is a power of 2 so the index wraps by truncation.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr_q + IW'(i);
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  // Next pointer: one past the winner on an accepted grant, otherwise unchanged.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = grant_id + IW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/adder_pipe_scheduler.sv
// Shares one pipelined adder among NREQ requesters: round-robin issue,
// requester-ID tag pipe aligned with the adder, and a credit-protected
// show-ahead result FIFO.
module adder_pipe_scheduler #(
  parameter int NREQ       = adder_sched_pkg::NREQ,
  parameter int WIDTH      = adder_sched_pkg::WIDTH,
  parameter int ADD_LAT    = adder_sched_pkg::ADD_LAT,
  parameter int FIFO_DEPTH = adder_sched_pkg::FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    sync_reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  input  logic [WIDTH-1:0]        add_sum,
  input  logic                    add_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  import adder_sched_pkg::*;

  // Arbitration / credit signals
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             issue;
  logic             arb_en;
  logic [CW-1:0]    credits_q;
  logic [CW-1:0]    credits_d;

  // Operand registers and their selected next values
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] add_a_q;
  logic [WIDTH-1:0] add_a_d;
  logic [WIDTH-1:0] add_b_q;
  logic [WIDTH-1:0] add_b_d;

  // Tag pipe: stage 0 travels with add_a/add_b, stages 1..ADD_LAT track the
  // adder's internal registers, so stage ADD_LAT lines up with add_sum.
  logic [ADD_LAT:0]          tag_vld_q;
  logic [ADD_LAT:0]          tag_vld_d;
  logic [ADD_LAT:0][IDW-1:0] tag_id_q;
  logic [ADD_LAT:0][IDW-1:0] tag_id_d;

  // Result FIFO
  rsp_entry_t    mem_q [FIFO_DEPTH];
  rsp_entry_t    mem_d [FIFO_DEPTH];
  rsp_entry_t    push_entry;
  rsp_entry_t    head_q;
  rsp_entry_t    head_d;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push;
  logic          pop;

  // ---- issue stage: arbitration gated by credits ----
  assign arb_en = (credits_q != '0) && !sync_reset;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk        (clk),
    .sync_reset (sync_reset),
    .req        (req_valid),
    .enable     (arb_en),
    .accept     (issue),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  // The arbiter only grants valid requests, so any grant is an accepted issue.
  assign issue     = |grant;
  assign req_ready = grant;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Operands load on issue and hold otherwise.
  always_comb begin
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    if (issue) begin
      add_a_d = sel_a;
      add_b_d = sel_b;
    end
  end

  // Credits track free FIFO slots not yet promised to in-flight operations.
  always_comb begin
    credits_d = credits_q;
    case ({issue, pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  // ---- adder stages: tag pipe shift ----
  always_comb begin
    tag_vld_d    = {tag_vld_q[ADD_LAT-1:0], issue};
    tag_id_d     = tag_id_q;
    tag_id_d[0]  = grant_id;
    for (int s = 1; s <= ADD_LAT; s++) begin
      tag_id_d[s] = tag_id_q[s-1];
    end
  end

  // ---- completion stage: FIFO push/pop ----
  assign push            = tag_vld_q[ADD_LAT];
  assign push_entry.id   = tag_id_q[ADD_LAT];
  assign push_entry.sum  = add_sum;
  assign push_entry.cout = add_cout;
  assign rsp_valid       = (count_q != '0);
  assign pop             = rsp_valid && rsp_ready;

  // Ring pointers, occupancy and storage write.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Head register: follows the new head, takes the pushed entry when it becomes head, holds when empty.
  always_comb begin
    head_d = head_q;
    if (push && ((count_q == '0) || (pop && (count_q == CW'(1))))) begin
      head_d = push_entry;
    end else if (count_d != '0) begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      credits_q <= CW'(FIFO_DEPTH);
      add_a_q   <= '0;
      add_b_q   <= '0;
      tag_vld_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_q    <= '0;
    end else begin
      credits_q <= credits_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      tag_vld_q <= tag_vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
    end
  end

  // Data-only storage: qualified by the valid bits above, so no reset needed.
  always_ff @(posedge clk) begin
    tag_id_q <= tag_id_d;
    mem_q    <= mem_d;
  end

  assign add_a    = add_a_q;
  assign add_b    = add_b_q;
  assign rsp_id   = head_q.id;
  assign rsp_sum  = head_q.sum;
  assign rsp_cout = head_q.cout;

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (sync_reset)
    push |-> (count_q != CW'(FIFO_DEPTH)));

endmodule
